// File: rtl/bdb_press_seq_pkg.sv
// Shared types for the press-pattern sequencer: FSM states, the descriptor
// record and a reference duration helper.
package bdb_press_seq_pkg;

  localparam int DESC_BOUNCE_W     = 8;
  localparam int DESC_HOLD_W       = 8;
  localparam int DEF_BOUNCE_CYCLES = 2;
  localparam int DEF_HOLD_UNIT     = 4;
  localparam int DEF_GAP_CYCLES    = 8;

  typedef enum logic [2:0] {
    IDLE,
    P_HI,
    P_LO,
    HOLD,
    R_LO,
    R_HI,
    GAP
  } seq_state_t;

  typedef struct packed {
    logic [DESC_BOUNCE_W-1:0] bounces;
    logic [DESC_HOLD_W-1:0]   hold;
  } bdb_press_desc_t;

  // Button cycles of one un-aborted operation at the default timing parameters.
  function automatic int unsigned press_cycles(input int unsigned bounces,
                                               input int unsigned hold);
    int unsigned hold_eff;
    hold_eff = (hold == 0) ? 1 : hold;
    return 4 * bounces * DEF_BOUNCE_CYCLES + hold_eff * DEF_HOLD_UNIT + DEF_GAP_CYCLES;
  endfunction

endpackage

// File: rtl/bdb_press_sequencer_timer.sv
// bdb_phase_timer: loadable down-counter that flags expiry when it reaches zero.
// Loading takes priority; the count then holds at zero until reloaded.
module bdb_phase_timer #(
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             load,
  input  logic [CNT_W-1:0] value,
  output logic             expire
);

  logic [CNT_W-1:0] count_reg;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      count_reg <= '0;
    end else if (load) begin
      count_reg <= value;
    end else if (count_reg != '0) begin
      count_reg <= count_reg - 1'b1;
    end
  end

  assign expire = (count_reg == '0);

endmodule

// File: rtl/bdb_press_sequencer.sv
// Press-pattern scheduler: turns (bounces, hold) descriptors into a bouncy
// button waveform. Optional stats outputs under BDB_PRESS_SEQ_STATS_EN.
module bdb_press_sequencer
  import bdb_press_seq_pkg::*;
#(
  parameter int BOUNCE_W      = 4,
  parameter int HOLD_W        = 4,
  parameter int BOUNCE_CYCLES = 2,
  parameter int HOLD_UNIT     = 4,
  parameter int GAP_CYCLES    = 8,
  parameter int CNT_W         = 16
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                op_valid,
  output logic                op_ready,
  input  logic [BOUNCE_W-1:0] op_bounces,
  input  logic [HOLD_W-1:0]   op_hold,
  input  logic                abort,
  output logic                button,
  output logic                busy,
  output logic                done
`ifdef BDB_PRESS_SEQ_STATS_EN
  ,
  output logic [CNT_W-1:0]    press_count,
  output logic [CNT_W-1:0]    abort_count
`endif
);

  if (BOUNCE_W > DESC_BOUNCE_W || HOLD_W > DESC_HOLD_W) begin : g_bad_desc_w
    $error("bdb_press_sequencer: descriptor fields wider than bdb_press_desc_t");
  end
  if ((longint'(1) << HOLD_W) * longint'(HOLD_UNIT) >= (longint'(1) << CNT_W)) begin : g_bad_cnt_w
    $error("bdb_press_sequencer: hold product does not fit in CNT_W");
  end
  if (BOUNCE_CYCLES < 1 || HOLD_UNIT < 1 || GAP_CYCLES < 1) begin : g_bad_timing
    $error("bdb_press_sequencer: timing parameters must be >= 1");
  end

  // Timer loads are duration-1 so the state lasts exactly `duration` clocks.
  localparam logic [CNT_W-1:0] BOUNCE_LOAD = CNT_W'(BOUNCE_CYCLES - 1);
  localparam logic [CNT_W-1:0] GAP_LOAD    = CNT_W'(GAP_CYCLES - 1);
  localparam logic [CNT_W-1:0] HOLD_UNIT_C = CNT_W'(HOLD_UNIT);

  seq_state_t               state_reg, state_next;
  bdb_press_desc_t          desc_reg, desc_next;
  logic [DESC_BOUNCE_W-1:0] bounce_left_reg, bounce_left_next;
  logic                     aborted_reg, aborted_next;
  logic                     button_reg, button_next;
  logic                     busy_reg, busy_next;
  logic                     done_reg, done_next;
  logic                     ready_reg, ready_next;

  logic                     timer_load;
  logic [CNT_W-1:0]         timer_value;
  logic                     timer_expire;
  logic [CNT_W-1:0]         hold_units;
  logic [CNT_W-1:0]         hold_load;

  bdb_phase_timer #(
    .CNT_W (CNT_W)
  ) u_timer (
    .clk    (clk),
    .reset  (reset),
    .load   (timer_load),
    .value  (timer_value),
    .expire (timer_expire)
  );

  always_comb begin
    state_next       = state_reg;
    desc_next        = desc_reg;
    bounce_left_next = bounce_left_reg;
    aborted_next     = aborted_reg;

    case (state_reg)
      IDLE: begin
        // op_ready is high exactly in IDLE, so op_valid here is an accept.
        if (op_valid) begin
          desc_next.bounces = DESC_BOUNCE_W'(op_bounces);
          desc_next.hold    = DESC_HOLD_W'(op_hold);
          bounce_left_next  = DESC_BOUNCE_W'(op_bounces);
          aborted_next      = 1'b0;
          state_next        = (op_bounces != '0) ? P_HI : HOLD;
        end
      end
      P_HI: if (timer_expire) state_next = P_LO;
      P_LO: begin
        if (timer_expire) begin
          bounce_left_next = bounce_left_reg - 1'b1;
          state_next = (bounce_left_reg != DESC_BOUNCE_W'(1)) ? P_HI : HOLD;
        end
      end
      HOLD: begin
        if (timer_expire) begin
          bounce_left_next = desc_reg.bounces;
          state_next = (desc_reg.bounces != '0) ? R_LO : GAP;
        end
      end
      R_LO: if (timer_expire) state_next = R_HI;
      R_HI: begin
        if (timer_expire) begin
          bounce_left_next = bounce_left_reg - 1'b1;
          state_next = (bounce_left_reg != DESC_BOUNCE_W'(1)) ? R_LO : GAP;
        end
      end
      GAP:     if (timer_expire) state_next = IDLE;
      default: state_next = IDLE;
    endcase

    if (abort && state_reg != IDLE && state_reg != GAP) begin
      state_next   = GAP;
      aborted_next = 1'b1;
    end

    // Every transition changes state, so a state change marks a fresh entry.
    hold_units  = (desc_next.hold == '0) ? CNT_W'(1) : CNT_W'(desc_next.hold);
    hold_load   = hold_units * HOLD_UNIT_C - 1'b1;
    timer_load  = (state_next != state_reg);
    case (state_next)
      HOLD:    timer_value = hold_load;
      GAP:     timer_value = GAP_LOAD;
      default: timer_value = BOUNCE_LOAD;
    endcase

    button_next = (state_next == P_HI) || (state_next == HOLD) || (state_next == R_HI);
    busy_next   = (state_next != IDLE);
    ready_next  = (state_next == IDLE);
    done_next   = (state_reg == GAP) && (state_next == IDLE);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_reg       <= IDLE;
      desc_reg        <= '0;
      bounce_left_reg <= '0;
      aborted_reg     <= 1'b0;
      button_reg      <= 1'b0;
      busy_reg        <= 1'b0;
      done_reg        <= 1'b0;
      ready_reg       <= 1'b1;
    end else begin
      state_reg       <= state_next;
      desc_reg        <= desc_next;
      bounce_left_reg <= bounce_left_next;
      aborted_reg     <= aborted_next;
      button_reg      <= button_next;
      busy_reg        <= busy_next;
      done_reg        <= done_next;
      ready_reg       <= ready_next;
    end
  end

  assign button   = button_reg;
  assign busy     = busy_reg;
  assign done     = done_reg;
  assign op_ready = ready_reg;

`ifdef BDB_PRESS_SEQ_STATS_EN
  logic [CNT_W-1:0] press_count_reg;
  logic [CNT_W-1:0] abort_count_reg;

  // Counted on the same edge that raises done, so they are current during the pulse.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      press_count_reg <= '0;
      abort_count_reg <= '0;
    end else if (done_next) begin
      if (aborted_reg) begin
        abort_count_reg <= abort_count_reg + 1'b1;
      end else begin
        press_count_reg <= press_count_reg + 1'b1;
      end
    end
  end

  assign press_count = press_count_reg;
  assign abort_count = abort_count_reg;
`endif

endmodule
